// File: rtl/core_pkg.sv
// Shared types for the core tile sequencer.
// States, psum SRAM source select and execution modes.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_RD,
    W_LOAD,
    X_RD,
    EXEC,
    DRAIN,
    ACC,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    ACC_RD,
    ACC_WB,
    ACC_CLR
  } acc_ph_t;

  localparam logic [1:0] PMEM_OFIFO = 2'd0;
  localparam logic [1:0] PMEM_SFP   = 2'd1;
  localparam logic [1:0] PMEM_EXT   = 2'd2;

  localparam logic EXEC_WS = 1'b0;
  localparam logic EXEC_OS = 1'b1;

endpackage

// File: rtl/core_tile_seq_counter.sv
// Loadable up-counter with a terminal-count flag.
// tc is high while count equals last.
module seq_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] din,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (ld) begin
      count <= din;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == last);

endmodule

// File: rtl/core_tile_seq.sv
// Autonomous tile sequencer for the systolic core (WS / OS schedules).
// Define CORE_TILE_SEQ_PERF_EN to add perf_cycles / perf_stall counters.
import core_pkg::*;

module core_tile_seq #(
  parameter int ROW    = 8,
  parameter int COL    = 8,
  parameter int ADDR_W = 11,
  parameter int KIJ_W  = 4,
  parameter int NX_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_mode,
  input  logic              cfg_relu,
  input  logic [KIJ_W-1:0]  cfg_num_kij,
  input  logic [NX_W-1:0]   cfg_num_x,
  input  logic [ADDR_W-1:0] cfg_xbase,
  input  logic [ADDR_W-1:0] cfg_wbase,
  input  logic [ADDR_W-1:0] cfg_pbase,
  input  logic [ADDR_W-1:0] cfg_obase,
  input  logic              ofifo_valid,
  input  logic              abort,
  output logic              xmem_cen,
  output logic              xmem_wen,
  output logic              xw_mode,
  output logic [ADDR_W-1:0] xmem_addr,
  output logic              l0_wr,
  output logic              l0_rd,
  output logic              load,
  output logic              execute,
  output logic              ififo_wr,
  output logic              ofifo_rd,
  output logic              pmem_cen,
  output logic              pmem_wen,
  output logic [ADDR_W-1:0] pmem_waddr,
  output logic [ADDR_W-1:0] pmem_raddr,
  output logic [1:0]        pmem_mode,
  output logic              sfp_reset,
  output logic              relu_en,
  output logic              execution_mode,
  output logic              busy,
  output logic              done
`ifdef CORE_TILE_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_stall
`endif
);

  localparam int CW = $clog2((1 << NX_W) + ROW + COL);

  state_t  state, state_nxt;
  acc_ph_t acc_ph, acc_ph_nxt;

  logic              mode_q, relu_q;
  logic [KIJ_W-1:0]  nkij_q;
  logic [NX_W-1:0]   nx_q;
  logic [ADDR_W-1:0] xb_q, wb_q, pb_q, ob_q;
  logic              l0_wr_q, ififo_wr_q, sfp_clr_q;
  logic              acc_clr;

  logic [CW-1:0]    r_cnt, r_last;
  logic [NX_W-1:0]  n_cnt, o_cnt;
  logic [KIJ_W-1:0] k_cnt;
  logic r_tc, n_tc, k_tc, o_tc;
  logic r_clr, r_en, n_clr, n_en;
  logic k_clr, k_en, o_clr, o_en;

  logic accept, kill;
  logic [ADDR_W-1:0] w_off, p_off;

  assign accept = start && (state == IDLE);
  assign kill   = abort && (state != IDLE);
  assign w_off  = ADDR_W'(k_cnt) * ADDR_W'(ROW);
  assign p_off  = ADDR_W'(k_cnt) * ADDR_W'(nx_q);

  seq_counter #(.W(CW)) u_r (
    .clk(clk), .reset(reset), .ld(r_clr), .din('0),
    .en(r_en), .last(r_last), .count(r_cnt), .tc(r_tc)
  );

  seq_counter #(.W(NX_W)) u_n (
    .clk(clk), .reset(reset), .ld(n_clr), .din('0),
    .en(n_en), .last(nx_q - NX_W'(1)), .count(n_cnt), .tc(n_tc)
  );

  seq_counter #(.W(KIJ_W)) u_k (
    .clk(clk), .reset(reset), .ld(k_clr), .din('0),
    .en(k_en), .last(nkij_q - KIJ_W'(1)), .count(k_cnt), .tc(k_tc)
  );

  seq_counter #(.W(NX_W)) u_o (
    .clk(clk), .reset(reset), .ld(o_clr), .din('0),
    .en(o_en), .last(nx_q - NX_W'(1)), .count(o_cnt), .tc(o_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      acc_ph     <= ACC_RD;
      l0_wr_q    <= 1'b0;
      ififo_wr_q <= 1'b0;
      sfp_clr_q  <= 1'b1;
      mode_q     <= 1'b0;
      relu_q     <= 1'b0;
      nkij_q     <= '0;
      nx_q       <= '0;
      xb_q       <= '0;
      wb_q       <= '0;
      pb_q       <= '0;
      ob_q       <= '0;
    end else begin
      state      <= state_nxt;
      acc_ph     <= acc_ph_nxt;
      l0_wr_q    <= !kill && ((state == W_RD && !mode_q) || state == X_RD);
      ififo_wr_q <= !kill && state == W_RD && mode_q;
      sfp_clr_q  <= kill;
      if (accept) begin
        mode_q <= cfg_mode;
        relu_q <= cfg_relu;
        nkij_q <= cfg_num_kij;
        nx_q   <= cfg_num_x;
        xb_q   <= cfg_xbase;
        wb_q   <= cfg_wbase;
        pb_q   <= cfg_pbase;
        ob_q   <= cfg_obase;
      end
    end
  end

  always_comb begin
    r_last = '0;
    case (state)
      W_RD:    r_last = CW'(ROW - 1);
      W_LOAD:  r_last = CW'(ROW + COL - 1);
      X_RD:    r_last = CW'(nx_q) - CW'(1);
      EXEC:    r_last = CW'(nx_q) + CW'(ROW + COL - 1);
      default: r_last = '0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    acc_ph_nxt = acc_ph;
    r_clr = 1'b0; r_en = 1'b0;
    n_clr = 1'b0; n_en = 1'b0;
    k_clr = 1'b0; k_en = 1'b0;
    o_clr = 1'b0; o_en = 1'b0;
    xmem_cen   = 1'b1;
    xw_mode    = 1'b0;
    xmem_addr  = '0;
    l0_rd      = 1'b0;
    load       = 1'b0;
    execute    = 1'b0;
    ofifo_rd   = 1'b0;
    pmem_cen   = 1'b1;
    pmem_wen   = 1'b1;
    pmem_waddr = '0;
    pmem_raddr = '0;
    pmem_mode  = PMEM_OFIFO;
    relu_en    = 1'b0;
    acc_clr    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          r_clr = 1'b1; n_clr = 1'b1;
          k_clr = 1'b1; o_clr = 1'b1;
          acc_ph_nxt = ACC_RD;
          if (cfg_num_kij == '0 || cfg_num_x == '0)
            state_nxt = DONE;
          else
            state_nxt = W_RD;
        end
      end
      W_RD: begin
        xmem_cen  = 1'b0;
        xw_mode   = 1'b1;
        xmem_addr = wb_q + w_off + ADDR_W'(r_cnt);
        r_en = 1'b1;
        if (r_tc) begin
          r_clr = 1'b1;
          state_nxt = mode_q ? X_RD : W_LOAD;
        end
      end
      W_LOAD: begin
        load  = 1'b1;
        l0_rd = 1'b1;
        r_en  = 1'b1;
        if (r_tc) begin
          r_clr = 1'b1;
          state_nxt = X_RD;
        end
      end
      X_RD: begin
        xmem_cen  = 1'b0;
        xmem_addr = xb_q + ADDR_W'(r_cnt);
        r_en = 1'b1;
        if (r_tc) begin
          r_clr = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        execute = 1'b1;
        l0_rd   = 1'b1;
        r_en    = 1'b1;
        if (r_tc) begin
          r_clr = 1'b1;
          // OS keeps partial sums in the array across kij
          if (!mode_q || k_tc) begin
            state_nxt = DRAIN;
          end else begin
            k_en = 1'b1;
            state_nxt = W_RD;
          end
        end
      end
      DRAIN: begin
        if (ofifo_valid) begin
          ofifo_rd   = 1'b1;
          pmem_cen   = 1'b0;
          pmem_wen   = 1'b0;
          pmem_waddr = pb_q + (mode_q ? '0 : p_off) + ADDR_W'(n_cnt);
          n_en = 1'b1;
          if (n_tc) begin
            n_clr = 1'b1;
            if (mode_q) begin
              state_nxt = DONE;
            end else if (k_tc) begin
              k_clr = 1'b1;
              o_clr = 1'b1;
              acc_ph_nxt = ACC_RD;
              state_nxt  = ACC;
            end else begin
              k_en = 1'b1;
              state_nxt = W_RD;
            end
          end
        end
      end
      ACC: begin
        case (acc_ph)
          ACC_RD: begin
            pmem_cen   = 1'b0;
            pmem_raddr = pb_q + p_off + ADDR_W'(o_cnt);
            k_en = 1'b1;
            if (k_tc) begin
              k_clr = 1'b1;
              acc_ph_nxt = ACC_WB;
            end
          end
          ACC_WB: begin
            pmem_cen   = 1'b0;
            pmem_wen   = 1'b0;
            pmem_mode  = PMEM_SFP;
            pmem_waddr = ob_q + ADDR_W'(o_cnt);
            relu_en    = relu_q;
            acc_ph_nxt = ACC_CLR;
          end
          ACC_CLR: begin
            acc_clr    = 1'b1;
            acc_ph_nxt = ACC_RD;
            if (o_tc) begin
              o_clr = 1'b1;
              state_nxt = DONE;
            end else begin
              o_en = 1'b1;
            end
          end
          default: acc_ph_nxt = ACC_RD;
        endcase
      end
      DONE: begin
        done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill) begin
      state_nxt  = IDLE;
      acc_ph_nxt = ACC_RD;
      r_clr = 1'b1; n_clr = 1'b1;
      k_clr = 1'b1; o_clr = 1'b1;
      r_en  = 1'b0; n_en  = 1'b0;
      k_en  = 1'b0; o_en  = 1'b0;
    end
  end

  assign xmem_wen       = 1'b1;
  assign l0_wr          = l0_wr_q;
  assign ififo_wr       = ififo_wr_q;
  assign sfp_reset      = sfp_clr_q | acc_clr;
  assign busy           = (state != IDLE) && (state != DONE);
  assign execution_mode = busy ? mode_q : EXEC_WS;

`ifdef CORE_TILE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy && perf_cycles != '1)
        perf_cycles <= perf_cycles + 32'd1;
      if (state == DRAIN && !ofifo_valid && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_tile_seq.sv
// Scoreboard bench for core_tile_seq: expected memory/done events
// are queued by the stimulus and popped by a negedge monitor.
module tb_core_tile_seq;

  localparam int K_XRD  = 0;
  localparam int K_PW   = 1;
  localparam int K_PR   = 2;
  localparam int K_DONE = 3;

  logic        clk, reset, start, cfg_mode, cfg_relu;
  logic [3:0]  cfg_num_kij;
  logic [5:0]  cfg_num_x;
  logic [10:0] cfg_xbase, cfg_wbase, cfg_pbase, cfg_obase;
  logic        ofifo_valid, abort;
  logic        xmem_cen, xmem_wen, xw_mode;
  logic [10:0] xmem_addr;
  logic        l0_wr, l0_rd, load, execute, ififo_wr, ofifo_rd;
  logic        pmem_cen, pmem_wen;
  logic [10:0] pmem_waddr, pmem_raddr;
  logic [1:0]  pmem_mode;
  logic        sfp_reset, relu_en, execution_mode, busy, done;
`ifdef CORE_TILE_SEQ_PERF_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  core_tile_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_mode(cfg_mode), .cfg_relu(cfg_relu),
    .cfg_num_kij(cfg_num_kij), .cfg_num_x(cfg_num_x),
    .cfg_xbase(cfg_xbase), .cfg_wbase(cfg_wbase),
    .cfg_pbase(cfg_pbase), .cfg_obase(cfg_obase),
    .ofifo_valid(ofifo_valid), .abort(abort),
    .xmem_cen(xmem_cen), .xmem_wen(xmem_wen), .xw_mode(xw_mode),
    .xmem_addr(xmem_addr), .l0_wr(l0_wr), .l0_rd(l0_rd),
    .load(load), .execute(execute), .ififo_wr(ififo_wr),
    .ofifo_rd(ofifo_rd), .pmem_cen(pmem_cen), .pmem_wen(pmem_wen),
    .pmem_waddr(pmem_waddr), .pmem_raddr(pmem_raddr),
    .pmem_mode(pmem_mode), .sfp_reset(sfp_reset), .relu_en(relu_en),
    .execution_mode(execution_mode), .busy(busy), .done(done)
`ifdef CORE_TILE_SEQ_PERF_EN
    ,
    .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [10:0] addr;
    logic [1:0]  md;
    logic        rl;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  int  load_cnt = 0;
  int  ififo_cnt = 0;

  function automatic void push(input int kind, input logic [10:0] a,
                               input logic [1:0] m, input logic r);
    ev_t e;
    e.kind = kind; e.addr = a; e.md = m; e.rl = r;
    exp_q.push_back(e);
  endfunction

  task automatic pop_cmp(input int kind, input logic [10:0] a,
                         input logic [1:0] m, input logic r);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d addr=%h mode=%0d", kind, a, m);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr !== a || e.md !== m || e.rl !== r) begin
        errors++;
        $display("FAIL event got kind=%0d addr=%h mode=%0d relu=%0d expected kind=%0d addr=%h mode=%0d relu=%0d",
                 kind, a, m, r, e.kind, e.addr, e.md, e.rl);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (!xmem_cen) pop_cmp(K_XRD, xmem_addr, {1'b0, xw_mode}, 1'b0);
      if (!pmem_cen && !pmem_wen) pop_cmp(K_PW, pmem_waddr, pmem_mode, relu_en);
      if (!pmem_cen && pmem_wen) pop_cmp(K_PR, pmem_raddr, pmem_mode, relu_en);
      if (done) begin
        done_cnt++;
        pop_cmp(K_DONE, 11'h0, 2'd0, 1'b0);
      end
      if (load) load_cnt++;
      if (ififo_wr) ififo_cnt++;
    end
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, want);
    end
  endtask

  // Expected event stream for one run; part=1 stops after kij 0 reads
  task automatic model(input bit m, input bit rl, input int nk, input int nx,
                       input logic [10:0] xb, wb, pb, ob, input bit part);
    if (nk == 0 || nx == 0) begin
      push(K_DONE, 11'h0, 2'd0, 1'b0);
      return;
    end
    for (int k = 0; k < nk; k++) begin
      for (int r = 0; r < 8; r++)
        push(K_XRD, 11'(int'(wb) + k * 8 + r), 2'd1, 1'b0);
      for (int n = 0; n < nx; n++)
        push(K_XRD, 11'(int'(xb) + n), 2'd0, 1'b0);
      if (part) return;
      if (!m)
        for (int n = 0; n < nx; n++)
          push(K_PW, 11'(int'(pb) + k * nx + n), 2'd0, 1'b0);
    end
    if (m) begin
      for (int n = 0; n < nx; n++)
        push(K_PW, 11'(int'(pb) + n), 2'd0, 1'b0);
    end else begin
      for (int o = 0; o < nx; o++) begin
        for (int k = 0; k < nk; k++)
          push(K_PR, 11'(int'(pb) + k * nx + o), 2'd0, 1'b0);
        push(K_PW, 11'(int'(ob) + o), 2'd1, rl);
      end
    end
    push(K_DONE, 11'h0, 2'd0, 1'b0);
  endtask

  task automatic go(input bit m, input bit rl, input int nk, input int nx,
                    input logic [10:0] xb, wb, pb, ob, input bit ab);
    @(negedge clk);
    cfg_mode = m; cfg_relu = rl;
    cfg_num_kij = 4'(nk); cfg_num_x = 6'(nx);
    cfg_xbase = xb; cfg_wbase = wb; cfg_pbase = pb; cfg_obase = ob;
    start = 1'b1; abort = ab;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    cfg_mode = ~m; cfg_relu = ~rl;
    cfg_num_kij = 4'd15; cfg_num_x = 6'd63;
    cfg_xbase = 11'h555; cfg_wbase = 11'h2AA;
    cfg_pbase = 11'h123; cfg_obase = 11'h321;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s timeout got no done expected done", nm);
    end
    repeat (3) @(negedge clk);
    check({nm, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_exec(input bit lvl, input string nm);
    int i = 0;
    while (execute !== lvl && i < 1000) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (execute !== lvl) begin
      errors++;
      $display("FAIL %s timeout execute=%0d expected %0d", nm, execute, lvl);
    end
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; ofifo_valid = 1'b1;
    cfg_mode = 1'b0; cfg_relu = 1'b0;
    cfg_num_kij = '0; cfg_num_x = '0;
    cfg_xbase = '0; cfg_wbase = '0; cfg_pbase = '0; cfg_obase = '0;
    #12;
    check("rst_low_en", 32'({xmem_cen, xmem_wen, pmem_cen, pmem_wen}), 32'hF);
    check("rst_strobes", 32'({l0_wr, l0_rd, load, execute, ififo_wr,
                              ofifo_rd, busy, done, relu_en, xw_mode}), 32'h0);
    check("rst_sfp", 32'(sfp_reset), 32'h1);
    check("rst_addr", 32'({xmem_addr, pmem_waddr, pmem_mode}), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // abort while idle does nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'h0);

    // WS, one kij, four vectors, relu on
    model(1'b0, 1'b1, 1, 4, 11'h100, 11'h200, 11'h300, 11'h400, 1'b0);
    go(1'b0, 1'b1, 1, 4, 11'h100, 11'h200, 11'h300, 11'h400, 1'b0);
    check("ws1_busy", 32'(busy), 32'h1);
    check("ws1_exec_mode", 32'(execution_mode), 32'h0);
    wait_done("ws1", 300);

    // start with abort in the same idle cycle; addresses wrap
    model(1'b0, 1'b0, 2, 4, 11'h7FC, 11'h7FC, 11'h7FE, 11'h7FF, 1'b0);
    go(1'b0, 1'b0, 2, 4, 11'h7FC, 11'h7FC, 11'h7FE, 11'h7FF, 1'b1);
    check("start_wins_busy", 32'(busy), 32'h1);
    wait_done("wrap", 400);

    // WS, nine kij, sixteen vectors
    model(1'b0, 1'b0, 9, 16, 11'h010, 11'h020, 11'h040, 11'h600, 1'b0);
    go(1'b0, 1'b0, 9, 16, 11'h010, 11'h020, 11'h040, 11'h600, 1'b0);
    wait_done("ws9", 3000);

    // five-cycle OFIFO stall at the start of DRAIN
    ofifo_valid = 1'b0;
    model(1'b0, 1'b0, 1, 2, 11'h0A0, 11'h0B0, 11'h0C0, 11'h0D0, 1'b0);
    go(1'b0, 1'b0, 1, 2, 11'h0A0, 11'h0B0, 11'h0C0, 11'h0D0, 1'b0);
    wait_exec(1'b1, "stall_exec_on");
    wait_exec(1'b0, "stall_exec_off");
    for (int i = 0; i < 5; i++) begin
      check("stall_quiet", 32'({ofifo_rd, pmem_cen, pmem_wen}), 32'h3);
      @(negedge clk);
    end
    ofifo_valid = 1'b1;
    wait_done("stall", 300);
`ifdef CORE_TILE_SEQ_PERF_EN
    check("perf_stall", perf_stall, 32'd5);
`endif

    // abort mid-EXEC, then a clean run
    model(1'b0, 1'b0, 1, 4, 11'h010, 11'h020, 11'h030, 11'h040, 1'b1);
    go(1'b0, 1'b0, 1, 4, 11'h010, 11'h020, 11'h030, 11'h040, 1'b0);
    wait_exec(1'b1, "abort_exec_on");
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_sfp", 32'(sfp_reset), 32'h1);
    check("abort_done", 32'(done), 32'h0);
    @(negedge clk);
    check("abort_sfp_pulse", 32'(sfp_reset), 32'h0);
    repeat (5) @(negedge clk);
    check("abort_drained", exp_q.size(), 0);
    model(1'b0, 1'b1, 1, 4, 11'h010, 11'h020, 11'h030, 11'h040, 1'b0);
    go(1'b0, 1'b1, 1, 4, 11'h010, 11'h020, 11'h030, 11'h040, 1'b0);
    wait_done("post_abort", 300);

    // OS mode: IFIFO fill, no load, single drain, no ACC
    load_cnt = 0;
    ififo_cnt = 0;
    model(1'b1, 1'b0, 3, 8, 11'h100, 11'h180, 11'h200, 11'h280, 1'b0);
    go(1'b1, 1'b0, 3, 8, 11'h100, 11'h180, 11'h200, 11'h280, 1'b0);
    check("os_exec_mode", 32'(execution_mode), 32'h1);
    wait_done("os", 500);
    check("os_load_cnt", load_cnt, 0);
    check("os_ififo_cnt", ififo_cnt, 24);

    // asynchronous reset while stalled in DRAIN
    ofifo_valid = 1'b0;
    model(1'b0, 1'b0, 1, 4, 11'h010, 11'h020, 11'h030, 11'h040, 1'b1);
    go(1'b0, 1'b0, 1, 4, 11'h010, 11'h020, 11'h030, 11'h040, 1'b0);
    wait_exec(1'b1, "rst_exec_on");
    wait_exec(1'b0, "rst_exec_off");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_sfp", 32'(sfp_reset), 32'h1);
    check("mid_rst_low_en", 32'({xmem_cen, xmem_wen, pmem_cen, pmem_wen}), 32'hF);
    check("mid_rst_strobes", 32'({l0_wr, l0_rd, load, execute, ififo_wr,
                                  ofifo_rd, done, pmem_mode}), 32'h0);
    check("mid_rst_drained", exp_q.size(), 0);
    @(negedge clk);
    reset = 1'b1;
    ofifo_valid = 1'b1;
    @(negedge clk);

    // zero-size configurations finish on the next cycle
    model(1'b0, 1'b0, 1, 0, 11'h0, 11'h0, 11'h0, 11'h0, 1'b0);
    go(1'b0, 1'b0, 1, 0, 11'h010, 11'h020, 11'h030, 11'h040, 1'b0);
    check("nx0_done", 32'(done), 32'h1);
    check("nx0_busy", 32'(busy), 32'h0);
    @(negedge clk);
    check("nx0_done_pulse", 32'(done), 32'h0);
    model(1'b0, 1'b0, 0, 4, 11'h0, 11'h0, 11'h0, 11'h0, 1'b0);
    go(1'b0, 1'b0, 0, 4, 11'h010, 11'h020, 11'h030, 11'h040, 1'b0);
    check("kij0_done", 32'(done), 32'h1);
    repeat (3) @(negedge clk);
    check("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
